// File: rtl/lcd_char_arbiter.sv
// lcd_char_arbiter: shares one character-LCD writer between two character
// sources. One character is forwarded per display-ready window; the first
// requester granted keeps the line until it sends a line-end (8'h0A or
// 8'h0D) or until MAX_BURST characters have gone out under one lock.
// Optional build macro LCD_ARB_TIMEOUT_EN: also releases the lock after the
// owner has been idle for TIMEOUT_CYCLES cycles.
module lcd_char_arbiter #(
    parameter int MAX_BURST      = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_Req0_Valid,
    input  logic [7:0] i_Req0_Char,
    output logic       o_Req0_Ack,
    input  logic       i_Req1_Valid,
    input  logic [7:0] i_Req1_Char,
    output logic       o_Req1_Ack,
    input  logic       i_Display_Ready,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Character,
    output logic       o_Owner,
    output logic       o_Locked
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SENT   = 2'd1,
        DRAIN  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // The idle counter must be able to hold TIMEOUT_CYCLES; an illegal
    // setting shows up as this marker block in the elaborated hierarchy.
    generate
        if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_timeout_w_too_small
        end
    endgenerate

    state_t               r_state;
    logic                 r_data_valid;
    logic [7:0]           r_data_char;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_owner;
    logic                 r_locked;
    logic                 r_rr;
    logic [BURST_W-1:0]   r_burst_cnt;

    state_t               w_state_next;
    logic                 w_data_valid_next;
    logic [7:0]           w_data_char_next;
    logic                 w_ack0_next;
    logic                 w_ack1_next;
    logic                 w_owner_next;
    logic                 w_locked_next;
    logic                 w_rr_next;
    logic [BURST_W-1:0]   w_burst_cnt_next;
    logic                 w_issue;
    logic                 w_winner;
    logic                 w_owner_valid;
    logic [7:0]           w_win_char;

`ifdef LCD_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_idle_cnt;
    logic [TIMEOUT_W-1:0] w_idle_cnt_next;
`endif

    function automatic logic is_line_end(input logic [7:0] c);
        return (c == 8'h0A) || (c == 8'h0D);
    endfunction

    // Next-state and next-output logic: arbitration, issue and lock release
    always_comb begin
        w_state_next      = r_state;
        w_data_valid_next = 1'b0;
        w_data_char_next  = r_data_char;
        w_ack0_next       = 1'b0;
        w_ack1_next       = 1'b0;
        w_owner_next      = r_owner;
        w_locked_next     = r_locked;
        w_rr_next         = r_rr;
        w_burst_cnt_next  = r_burst_cnt;
        w_issue           = 1'b0;
        w_winner          = 1'b0;
        w_owner_valid     = r_owner ? i_Req1_Valid : i_Req0_Valid;
`ifdef LCD_ARB_TIMEOUT_EN
        w_idle_cnt_next   = '0;
`endif

        case (r_state)
            IDLE: begin
                if (i_Display_Ready && (i_Req0_Valid || i_Req1_Valid)) begin
                    w_issue  = 1'b1;
                    w_winner = (i_Req0_Valid && i_Req1_Valid) ? r_rr : i_Req1_Valid;
                end
            end
            SENT: begin
                // Writer acknowledges the strobe by dropping ready
                if (!i_Display_Ready) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (i_Display_Ready) begin
                    w_state_next = r_locked ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (w_owner_valid) begin
                    if (i_Display_Ready) begin
                        w_issue  = 1'b1;
                        w_winner = r_owner;
                    end
                end
`ifdef LCD_ARB_TIMEOUT_EN
                else if (r_idle_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Owner went quiet mid-line: hand the display to the other side
                    w_locked_next    = 1'b0;
                    w_burst_cnt_next = '0;
                    w_rr_next        = ~r_owner;
                    w_state_next     = IDLE;
                end else begin
                    w_idle_cnt_next = r_idle_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_win_char = w_winner ? i_Req1_Char : i_Req0_Char;

        if (w_issue) begin
            w_data_valid_next = 1'b1;
            w_data_char_next  = w_win_char;
            w_ack0_next       = ~w_winner;
            w_ack1_next       = w_winner;
            w_owner_next      = w_winner;
            w_state_next      = SENT;
            if (is_line_end(w_win_char) ||
                (r_burst_cnt == BURST_W'(MAX_BURST - 1))) begin
                w_locked_next    = 1'b0;
                w_burst_cnt_next = '0;
                w_rr_next        = ~w_winner;
            end else begin
                w_locked_next    = 1'b1;
                w_burst_cnt_next = r_burst_cnt + 1'b1;
            end
        end
    end

    // State and output registers; reset drops any in-flight strobe at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_data_valid <= 1'b0;
            r_data_char  <= 8'h00;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_owner      <= 1'b0;
            r_locked     <= 1'b0;
            r_rr         <= 1'b0;
            r_burst_cnt  <= '0;
`ifdef LCD_ARB_TIMEOUT_EN
            r_idle_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_data_valid <= w_data_valid_next;
            r_data_char  <= w_data_char_next;
            r_ack0       <= w_ack0_next;
            r_ack1       <= w_ack1_next;
            r_owner      <= w_owner_next;
            r_locked     <= w_locked_next;
            r_rr         <= w_rr_next;
            r_burst_cnt  <= w_burst_cnt_next;
`ifdef LCD_ARB_TIMEOUT_EN
            r_idle_cnt   <= w_idle_cnt_next;
`endif
        end
    end

    assign o_Data_Valid     = r_data_valid;
    assign o_Data_Character = r_data_char;
    assign o_Req0_Ack       = r_ack0;
    assign o_Req1_Ack       = r_ack1;
    assign o_Owner          = r_owner;
    assign o_Locked         = r_locked;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Bench for lcd_char_arbiter: two requester agents, a writer model that
// drops ready after each strobe, and a scoreboard of expected strobes.
module tb_lcd_char_arbiter;

    logic       clock;
    logic       reset;
    logic       i_Req0_Valid;
    logic [7:0] i_Req0_Char;
    logic       o_Req0_Ack;
    logic       i_Req1_Valid;
    logic [7:0] i_Req1_Char;
    logic       o_Req1_Ack;
    logic       i_Display_Ready;
    logic       o_Data_Valid;
    logic [7:0] o_Data_Character;
    logic       o_Owner;
    logic       o_Locked;

    logic       writer_ready;
    logic       force_low;

    typedef struct packed {
        logic [7:0] ch;
        logic       owner;
        logic       locked;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int n_compared;
    int n_mismatched;
    int strobe_cnt;

    lcd_char_arbiter #(
        .MAX_BURST      (4),
        .TIMEOUT_CYCLES (100),
        .TIMEOUT_W      (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .i_Req0_Valid     (i_Req0_Valid),
        .i_Req0_Char      (i_Req0_Char),
        .o_Req0_Ack       (o_Req0_Ack),
        .i_Req1_Valid     (i_Req1_Valid),
        .i_Req1_Char      (i_Req1_Char),
        .o_Req1_Ack       (o_Req1_Ack),
        .i_Display_Ready  (i_Display_Ready),
        .o_Data_Valid     (o_Data_Valid),
        .o_Data_Character (o_Data_Character),
        .o_Owner          (o_Owner),
        .o_Locked         (o_Locked)
    );

    assign i_Display_Ready = writer_ready && !force_low;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_char(input logic [7:0] c, input logic own, input logic lk);
        exp_t e;
        e.ch = c;
        e.owner = own;
        e.locked = lk;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (10) @(negedge clock);
        check_val(tag, exp_q.size(), 0);
    endtask

    // Writer model: busy for a few cycles after every strobe
    initial begin
        writer_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (o_Data_Valid && !reset) begin
                writer_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                writer_ready = 1'b1;
            end
        end
    end

    // Requester agents: present queue head, advance on ack
    initial begin
        i_Req0_Valid = 1'b0; i_Req0_Char = 8'h00;
        i_Req1_Valid = 1'b0; i_Req1_Char = 8'h00;
        forever begin
            @(negedge clock);
            if (o_Req0_Ack && q0.size() != 0) void'(q0.pop_front());
            if (o_Req1_Ack && q1.size() != 0) void'(q1.pop_front());
            i_Req0_Valid = (q0.size() != 0);
            i_Req0_Char  = (q0.size() != 0) ? q0[0] : 8'h00;
            i_Req1_Valid = (q1.size() != 0);
            i_Req1_Char  = (q1.size() != 0) ? q1[0] : 8'h00;
        end
    end

    // Scoreboard monitor: every strobe is popped and compared
    initial begin
        logic prev_dv;
        exp_t e;
        prev_dv = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_dv = 1'b0;
            end else begin
                if (o_Data_Valid) begin
                    strobe_cnt++;
                    $display("strobe char=%02h owner=%0d locked=%0d ack=%b%b",
                             o_Data_Character, o_Owner, o_Locked, o_Req1_Ack, o_Req0_Ack);
                    check_val("dv_single_cycle", prev_dv, 0);
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_strobe", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("char", o_Data_Character, e.ch);
                        check_val("owner", o_Owner, e.owner);
                        check_val("locked", o_Locked, e.locked);
                        check_val("ack", {o_Req1_Ack, o_Req0_Ack}, e.owner ? 2 : 1);
                    end
                end else if (o_Req0_Ack || o_Req1_Ack) begin
                    check_val("stray_ack", {o_Req1_Ack, o_Req0_Ack}, 0);
                end
                prev_dv = o_Data_Valid;
            end
        end
    end

    initial begin
        int  base;
        logic seen;
        n_compared = 0;
        n_mismatched = 0;
        strobe_cnt = 0;
        force_low = 1'b0;
        reset = 1'b1;

        // Reset values
        repeat (3) @(negedge clock);
        check_val("rst_dv", o_Data_Valid, 0);
        check_val("rst_char", o_Data_Character, 0);
        check_val("rst_ack0", o_Req0_Ack, 0);
        check_val("rst_ack1", o_Req1_Ack, 0);
        check_val("rst_owner", o_Owner, 0);
        check_val("rst_locked", o_Locked, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Both valid with rr=0: req0 owns the line until its CR
        q0.push_back("A"); q0.push_back("B"); q0.push_back(8'h0D);
        q1.push_back("X"); q1.push_back(8'h0D);
        expect_char("A", 0, 1); expect_char("B", 0, 1); expect_char(8'h0D, 0, 0);
        expect_char("X", 1, 1); expect_char(8'h0D, 1, 0);
        wait_done("line_done", 400);

        // Burst limit of 4 forces release, req1 gets in before req0's 5th char
        q0.push_back("0"); q0.push_back("1"); q0.push_back("2");
        q0.push_back("3"); q0.push_back("4"); q0.push_back("5");
        q1.push_back("Y"); q1.push_back(8'h0D);
        expect_char("0", 0, 1); expect_char("1", 0, 1); expect_char("2", 0, 1);
        expect_char("3", 0, 0);
        expect_char("Y", 1, 1); expect_char(8'h0D, 1, 0);
        expect_char("4", 0, 1); expect_char("5", 0, 1);
        wait_done("burst_done", 600);

        // req0 holds the lock but goes quiet; req1 waits
        base = strobe_cnt;
        q1.push_back("Z"); q1.push_back(8'h0A);
`ifdef LCD_ARB_TIMEOUT_EN
        expect_char("Z", 1, 1); expect_char(8'h0A, 1, 0);
        repeat (200) @(negedge clock);
        check_val("timeout_grants", strobe_cnt - base, 2);
        check_val("timeout_unlocked", o_Locked, 0);
        q0.push_back(8'h0D);
        expect_char(8'h0D, 0, 0);
`else
        repeat (200) @(negedge clock);
        check_val("lock_held_no_strobe", strobe_cnt - base, 0);
        check_val("lock_held_locked", o_Locked, 1);
        check_val("lock_held_owner", o_Owner, 0);
        q0.push_back(8'h0D);
        expect_char(8'h0D, 0, 0); expect_char("Z", 1, 1); expect_char(8'h0A, 1, 0);
`endif
        wait_done("hold_done", 400);

        // Ready low for 500 cycles: request stays pending, then 1-cycle latency
        @(negedge clock);
        force_low = 1'b1;
        base = strobe_cnt;
        q1.push_back("R"); q1.push_back(8'h0A);
        repeat (500) @(negedge clock);
        check_val("ready_low_no_strobe", strobe_cnt - base, 0);
        expect_char("R", 1, 1); expect_char(8'h0A, 1, 0);
        force_low = 1'b0;
        @(negedge clock);
        check_val("strobe_latency", o_Data_Valid, 1);
        wait_done("ready_done", 400);

        // req0 finishes a line so rr points at req1
        q0.push_back("Q"); q0.push_back(8'h0D);
        expect_char("Q", 0, 1); expect_char(8'h0D, 0, 0);
        wait_done("q_done", 400);

        // Reset asserted while a strobe is out (state SENT)
        q0.push_back("S");
        expect_char("S", 0, 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (o_Data_Valid) seen = 1'b1;
        end
        check_val("s_strobe_seen", seen, 1);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_dv", o_Data_Valid, 0);
        check_val("async_rst_char", o_Data_Character, 0);
        check_val("async_rst_ack0", o_Req0_Ack, 0);
        check_val("async_rst_locked", o_Locked, 0);
        q0.delete(); q1.delete(); exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // After reset rr=0 again: req0 wins a simultaneous request
        q0.push_back("C"); q0.push_back(8'h0D);
        q1.push_back("D"); q1.push_back(8'h0D);
        expect_char("C", 0, 1); expect_char(8'h0D, 0, 0);
        expect_char("D", 1, 1); expect_char(8'h0D, 1, 0);
        wait_done("post_reset_done", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/lcd_char_arbiter.md
# lcd_char_arbiter

Two-port arbiter that shares the single character LCD writer between two character sources, for example the UART receive stream and a local status-message generator. Each source offers one character at a time. The arbiter forwards exactly one character per display-ready window using the writer's `i_Data_Valid`/`o_Display_Ready` handshake. A source keeps ownership until it ends its line, so lines from the two sources never interleave on the display.

## Interface
- `MAX_BURST`, default 32: maximum characters forwarded under one lock before ownership is forcibly released.
- `TIMEOUT_CYCLES`, default 1000000: owner-idle cycles before the lock is released (only with `LCD_ARB_TIMEOUT_EN`).
- `TIMEOUT_W`, default 20: width of the idle counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_Req0_Valid`  in  1  requester 0 has a character; held high until acknowledged.
- `i_Req0_Char`  in  8  requester 0 character; stable while valid.
- `o_Req0_Ack`  out  1  one-cycle pulse: requester 0 character forwarded.
- `i_Req1_Valid`, `i_Req1_Char`, `o_Req1_Ack`: same as above, for requester 1.
- `i_Display_Ready`  in  1  LCD writer ready; from the writer's `o_Display_Ready`.
- `o_Data_Valid`  out  1  one-cycle strobe to the writer's `i_Data_Valid`.
- `o_Data_Character`  out  8  character to the writer, registered.
- `o_Owner`  out  1  index of the current or last granted requester.
- `o_Locked`  out  1  a requester holds line ownership.

## Operation
- State machine states: IDLE, SENT, DRAIN, LOCKED.
- Shared issue action, from IDLE or LOCKED:
  - Register `o_Data_Valid`=1 and `o_Data_Character`=winner's character.
  - Pulse the winner's ack.
  - Set `o_Owner`=winner and increment the burst counter.
  - Go to SENT.
- IDLE:
  - Issue only when `i_Display_Ready`=1 and at least one request is valid.
  - If both are valid, the round-robin pointer `rr` selects the winner.
  - On issue, `o_Locked`=1 unless the character is a line-end.
- SENT: `o_Data_Valid`=0 and acks=0. Wait for `i_Display_Ready`=0, then go to DRAIN.
- DRAIN: wait for `i_Display_Ready`=1, then go to LOCKED if `o_Locked`=1, else IDLE.
- LOCKED:
  - Only the owner is serviced; the other requester waits regardless of its valid.
  - Issue when the owner is valid and `i_Display_Ready`=1.
- Line-end is 8'h0A or 8'h0D.
- Lock release happens when the issued character is a line-end, or when the burst counter reaches `MAX_BURST`. On release:
  - Clear `o_Locked` and the burst counter.
  - Set `rr` = ~owner.
  - The state still passes through SENT and DRAIN, then goes to IDLE.
- The burst counter is $clog2(MAX_BURST+1) bits wide and never wraps; it is cleared on every release.
- Characters are forwarded unmodified; no translation is done here.
- Reset mid-operation: all state is cleared immediately and any in-flight strobe is dropped. The writer has its own reset and is reset alongside.

## Timing
- Reset values:
  - `o_Data_Valid`=0, `o_Data_Character`=8'h00.
  - `o_Req0_Ack`=0, `o_Req1_Ack`=0.
  - `o_Owner`=0, `o_Locked`=0.
  - State=IDLE, `rr`=0, counters=0.
- Latency: request valid with ready high in IDLE/LOCKED at edge N gives `o_Data_Valid` and ack high during cycle N+1.
- `o_Data_Valid` is never high for more than one cycle.
- Minimum spacing between strobes is 3 cycles (SENT, DRAIN, issue). In practice it is set by the writer's busy time.
- A requester may drop or change valid/char in the cycle after its ack. The arbiter does not sample requests in SENT or DRAIN.
- Requests arriving while `i_Display_Ready`=0 are held pending with no ack.
- Simultaneous release and new request: release takes effect first, then IDLE arbitration starts in the following cycle.

## Configuration
- `LCD_ARB_TIMEOUT_EN` defined:
  - In LOCKED, an idle counter increments each cycle the owner's valid is low, and clears when it is high.
  - At `TIMEOUT_CYCLES` the lock releases: `o_Locked`=0, `rr`=~owner, go to IDLE.
- Not defined: no idle counter. The lock persists until a line-end or `MAX_BURST` is reached.

## Test plan
- Reset asserted mid-SENT: all outputs read 0 asynchronously, before the next clock edge. After release, state is IDLE with `rr`=0.
- Both requesters valid in IDLE, ready=1, `rr`=0: req0 receives the ack and `o_Data_Character`=req0 char. The req1 request receives no ack while req0 holds the lock.
- req0 sends "AB" then 8'h0D: three strobes go out, each only after ready toggles low then high. `o_Locked` falls after the 8'h0D. req1's pending character is forwarded next.
- `MAX_BURST`=4, req0 streams 6 characters with no line-end: after the 4th character, release occurs and `rr`=1. req1, if valid, is granted before req0's 5th character.
- req1 valid while ready=0 for 500 cycles: no strobe and no ack. The strobe appears exactly 1 cycle after ready rises.
- With `LCD_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: req0 locks, then goes idle. The lock releases after 100 idle cycles and req1 is granted. Without the macro, req1 is never granted.
